// File: rtl/axi_llc_read_unit.sv
// LLC read unit: splits a read descriptor into per-beat data-storage reads,
// tracks in-flight beats in a small metadata FIFO, returns data on the AXI
// R channel and unlocks the cache line after the final beat.
// The top two descriptor bits above id are reserved and ignored.
module axi_llc_read_unit #(
  parameter int unsigned AddrWidth         = 64,
  parameter int unsigned DataWidth         = 64,
  parameter int unsigned IdWidth           = 6,
  parameter int unsigned WayIndWidth       = 8,
  parameter int unsigned IndexLength       = 8,
  parameter int unsigned BlockOffsetLength = 3,
  parameter int unsigned MetaDepth         = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [IdWidth+AddrWidth+18+WayIndWidth-1:0]   desc_i,
  input  logic                                          desc_valid_i,
  output logic                                          desc_ready_o,
  output logic [IndexLength+BlockOffsetLength+WayIndWidth-1:0] way_req_o,
  output logic                                          way_req_valid_o,
  input  logic                                          way_req_ready_i,
  input  logic [DataWidth-1:0]                          way_rsp_data_i,
  input  logic                                          way_rsp_valid_i,
  output logic                                          way_rsp_ready_o,
  output logic [IdWidth+DataWidth+3-1:0]                r_chan_o,
  output logic                                          r_valid_o,
  input  logic                                          r_ready_i,
  output logic [IndexLength+WayIndWidth-1:0]            unlock_o,
  output logic                                          unlock_req_o,
  input  logic                                          unlock_gnt_i
);

  localparam int unsigned ByteOffsetLength = $clog2(DataWidth / 8);
  localparam int unsigned PtrWidth = (MetaDepth > 1) ? $clog2(MetaDepth) : 1;
  localparam int unsigned CntWidth = $clog2(MetaDepth + 1);
  localparam logic [1:0]  RespSlvErr = 2'b10;
  localparam logic [1:0]  BurstFixed = 2'b00;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                   state_q;
  logic [IdWidth-1:0]       id_q;
  logic [AddrWidth-1:0]     addr_q;
  logic [7:0]               len_q;
  logic [2:0]               size_q;
  logic [1:0]               burst_q;
  logic [1:0]               resp_q;
  logic                     last_q;
  logic [WayIndWidth-1:0]   way_q;

  // Descriptor fields, packed id (MSB) down to way_ind (LSB).
  logic [WayIndWidth-1:0]   d_way;
  logic                     d_last;
  logic [1:0]               d_resp;
  logic [1:0]               d_burst;
  logic [2:0]               d_size;
  logic [7:0]               d_len;
  logic [AddrWidth-1:0]     d_addr;
  logic [IdWidth-1:0]       d_id;

  assign d_way   = desc_i[WayIndWidth-1:0];
  assign d_last  = desc_i[WayIndWidth];
  assign d_resp  = desc_i[WayIndWidth+1 +: 2];
  assign d_burst = desc_i[WayIndWidth+3 +: 2];
  assign d_size  = desc_i[WayIndWidth+5 +: 3];
  assign d_len   = desc_i[WayIndWidth+8 +: 8];
  assign d_addr  = desc_i[WayIndWidth+16 +: AddrWidth];
  assign d_id    = desc_i[WayIndWidth+16+AddrWidth +: IdWidth];

  // Metadata FIFO storage, one field per array.
  logic [IdWidth-1:0]       m_id    [MetaDepth];
  logic [1:0]               m_resp  [MetaDepth];
  logic                     m_err   [MetaDepth];
  logic                     m_rlast [MetaDepth];
  logic                     m_final [MetaDepth];
  logic [IndexLength-1:0]   m_index [MetaDepth];
  logic [WayIndWidth-1:0]   m_way   [MetaDepth];
  logic [PtrWidth-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]      cnt_q;

  logic                         busy, err_beat, beat_final, fifo_full, fifo_empty;
  logic                         consume, load, r_hs;
  logic [IndexLength-1:0]       line_addr;
  logic [BlockOffsetLength-1:0] blk_offset;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MetaDepth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  // Handshake and datapath decode; every valid is forced low while in reset.
  always_comb begin
    busy            = (state_q == StBusy);
    err_beat        = (resp_q == RespSlvErr);
    beat_final      = (len_q == 8'd0);
    fifo_full       = (cnt_q == CntWidth'(MetaDepth));
    fifo_empty      = (cnt_q == '0);
    line_addr       = addr_q[ByteOffsetLength+BlockOffsetLength +: IndexLength];
    blk_offset      = addr_q[ByteOffsetLength +: BlockOffsetLength];
    way_req_o       = {line_addr, blk_offset, way_q};
    way_req_valid_o = !rst_i && busy && !err_beat && !fifo_full;
    consume         = !rst_i && busy && !fifo_full && (err_beat || way_req_ready_i);
    desc_ready_o    = rst_i || !busy || (consume && beat_final);
    load            = !rst_i && desc_valid_i && desc_ready_o;
    r_valid_o       = !rst_i && !fifo_empty && (m_err[rd_ptr_q] || way_rsp_valid_i) &&
                      (!m_final[rd_ptr_q] || unlock_gnt_i);
    r_hs            = r_valid_o && r_ready_i;
    way_rsp_ready_o = r_hs && !m_err[rd_ptr_q];
    unlock_req_o    = r_hs && m_final[rd_ptr_q];
    unlock_o        = {m_index[rd_ptr_q], m_way[rd_ptr_q]};
    r_chan_o        = {m_id[rd_ptr_q],
                       m_err[rd_ptr_q] ? {DataWidth{1'b0}} : way_rsp_data_i,
                       m_resp[rd_ptr_q], m_rlast[rd_ptr_q]};
  end

  // Descriptor register and IDLE/BUSY control; a new descriptor may load on the final beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      resp_q  <= '0;
      last_q  <= 1'b0;
      way_q   <= '0;
    end else if (load) begin
      state_q <= StBusy;
      id_q    <= d_id;
      addr_q  <= d_addr;
      len_q   <= d_len;
      size_q  <= d_size;
      burst_q <= d_burst;
      resp_q  <= d_resp;
      last_q  <= d_last;
      way_q   <= d_way;
    end else if (consume) begin
      if (beat_final) begin
        state_q <= StIdle;
      end else begin
        len_q <= len_q - 8'd1;
        // WRAP is advanced like INCR; wrapping bursts are split upstream.
        if (burst_q != BurstFixed) begin
          addr_q <= addr_q + (AddrWidth'(1) << size_q);
        end
      end
    end
  end

  // Metadata FIFO contents, written on every consumed beat.
  always_ff @(posedge clk_i) begin
    if (consume) begin
      m_id[wr_ptr_q]    <= id_q;
      m_resp[wr_ptr_q]  <= resp_q;
      m_err[wr_ptr_q]   <= err_beat;
      m_rlast[wr_ptr_q] <= beat_final && last_q;
      m_final[wr_ptr_q] <= beat_final;
      m_index[wr_ptr_q] <= line_addr;
      m_way[wr_ptr_q]   <= way_q;
    end
  end

  // Metadata FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (consume) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (r_hs)    rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({consume, r_hs})
        2'b10:   cnt_q <= cnt_q + CntWidth'(1);
        2'b01:   cnt_q <= cnt_q - CntWidth'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_llc_read_unit.sv
// Bench for axi_llc_read_unit: a beat-level model expands each accepted
// descriptor into expected storage reads and R beats; an in-order storage
// model answers requests; directed tests pin model results with literals.
module tb_axi_llc_read_unit;

  logic        clk, rst;
  logic [95:0] desc;
  logic        desc_valid, desc_ready;
  logic [18:0] way_req;
  logic        way_req_valid, way_req_ready;
  logic [63:0] way_rsp_data;
  logic        way_rsp_valid, way_rsp_ready;
  logic [72:0] r_chan;
  logic        r_valid, r_ready;
  logic [15:0] unlock;
  logic        unlock_req, unlock_gnt;

  axi_llc_read_unit dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .desc_i          (desc),
    .desc_valid_i    (desc_valid),
    .desc_ready_o    (desc_ready),
    .way_req_o       (way_req),
    .way_req_valid_o (way_req_valid),
    .way_req_ready_i (way_req_ready),
    .way_rsp_data_i  (way_rsp_data),
    .way_rsp_valid_i (way_rsp_valid),
    .way_rsp_ready_o (way_rsp_ready),
    .r_chan_o        (r_chan),
    .r_valid_o       (r_valid),
    .r_ready_i       (r_ready),
    .unlock_o        (unlock),
    .unlock_req_o    (unlock_req),
    .unlock_gnt_i    (unlock_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sdata(input logic [18:0] req);
    return {7'h55, req, req, req} ^ 64'hC0FF_EE00_1234_5678;
  endfunction

  function automatic logic [95:0] mk_desc(input logic [5:0] id, input logic [63:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
      input logic [1:0] resp, input logic last, input logic [7:0] way);
    return {2'b00, id, addr, len, size, burst, resp, last, way};
  endfunction

  // Model state
  logic [18:0] exp_wq[$];
  logic        exp_wfin[$];
  logic [72:0] exp_r[$];
  logic        exp_fin[$];
  logic        exp_err[$];
  logic [15:0] exp_unl[$];

  // Stimulus/storage state
  logic [95:0] desc_q[$];
  logic [18:0] stor_q[$];
  logic        hs_desc = 1'b0, hs_wreq = 1'b0, hs_rsp = 1'b0;
  logic [18:0] wreq_word = '0;
  logic        stor_flush = 1'b0;

  // Observation counters
  int cyc = 0, n_wreq = 0, n_r = 0, n_unl = 0, n_rlast = 0;
  int          wreq_cyc[$];
  int          desc_cyc[$];
  logic [2:0]  blk_log[$];
  logic [72:0] last_r = '0;
  logic [15:0] last_unl = '0;

  // Expand one descriptor into its beats using plain address arithmetic.
  task automatic expand(input logic [95:0] d);
    logic [7:0]  way   = d[7:0];
    logic        last  = d[8];
    logic [1:0]  resp  = d[10:9];
    logic [1:0]  burst = d[12:11];
    logic [2:0]  size  = d[15:13];
    logic [7:0]  len   = d[23:16];
    logic [63:0] addr  = d[87:24];
    logic [5:0]  id    = d[93:88];
    logic [63:0] a;
    logic [7:0]  idx;
    logic [2:0]  blk;
    logic [18:0] req;
    logic        err, fin;
    for (int k = 0; k <= int'(len); k++) begin
      a   = (burst == 2'b00) ? addr : addr + (64'(k) << size);
      idx = 8'((a >> 6) & 64'hFF);
      blk = 3'((a >> 3) & 64'h7);
      req = {idx, blk, way};
      err = (resp == 2'b10);
      fin = (k == int'(len));
      if (!err) begin
        exp_wq.push_back(req);
        exp_wfin.push_back(fin);
      end
      exp_r.push_back({id, err ? 64'h0 : sdata(req), resp, fin && last});
      exp_fin.push_back(fin);
      exp_err.push_back(err);
      exp_unl.push_back({idx, way});
    end
  endtask

  // Compare process: sample mid-cycle, check every handshake against the model.
  always @(negedge clk) begin
    logic hs_r;
    cyc++;
    if (rst) begin
      exp_wq.delete(); exp_wfin.delete(); exp_r.delete();
      exp_fin.delete(); exp_err.delete(); exp_unl.delete();
      hs_desc = 1'b0; hs_wreq = 1'b0; hs_rsp = 1'b0;
      stor_flush = 1'b1;
    end else begin
      hs_desc   = desc_valid && desc_ready;
      hs_wreq   = way_req_valid && way_req_ready;
      hs_rsp    = way_rsp_valid && way_rsp_ready;
      wreq_word = way_req;
      if (hs_wreq) begin
        n_wreq++;
        wreq_cyc.push_back(cyc);
        blk_log.push_back(way_req[10:8]);
        if (exp_wq.size() == 0) begin
          chk("wreq_unexpected", 1'b1, 1'b0);
        end else begin
          chk("wreq", way_req, exp_wq[0]);
          if (exp_wfin[0]) chk("desc_ready_on_last", desc_ready, 1'b1);
          void'(exp_wq.pop_front());
          void'(exp_wfin.pop_front());
        end
      end
      if (exp_r.size() == 0) begin
        chk("r_idle", {r_valid, unlock_req, way_rsp_ready}, 3'b000);
      end else begin
        if (exp_fin[0] && !unlock_gnt) chk("r_wait_gnt", r_valid, 1'b0);
        hs_r = r_valid && r_ready;
        chk("rsp_ready", way_rsp_ready, hs_r && !exp_err[0]);
        chk("unlock_req", unlock_req, hs_r && exp_fin[0]);
        if (hs_r) begin
          chk("r_beat", r_chan, exp_r[0]);
          if (exp_fin[0]) begin
            chk("unlock", unlock, exp_unl[0]);
            n_unl++;
            last_unl = unlock;
          end
          n_r++;
          if (r_chan[0]) n_rlast++;
          last_r = r_chan;
          void'(exp_r.pop_front()); void'(exp_fin.pop_front());
          void'(exp_err.pop_front()); void'(exp_unl.pop_front());
        end
      end
      if (hs_desc) begin
        expand(desc);
        desc_cyc.push_back(cyc);
      end
    end
  end

  // Drivers: descriptor source and in-order storage, updated just after the edge.
  initial begin
    desc_valid    = 1'b0;
    desc          = '0;
    way_rsp_valid = 1'b0;
    way_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stor_flush) begin
        stor_q.delete();
        stor_flush = 1'b0;
      end else begin
        if (hs_rsp && stor_q.size() > 0) void'(stor_q.pop_front());
        if (hs_wreq) stor_q.push_back(wreq_word);
        if (hs_desc && desc_q.size() > 0) void'(desc_q.pop_front());
      end
      desc_valid    = (desc_q.size() > 0);
      desc          = desc_valid ? desc_q[0] : '0;
      way_rsp_valid = (stor_q.size() > 0);
      way_rsp_data  = way_rsp_valid ? sdata(stor_q[0]) : '0;
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while (desc_q.size() != 0 || exp_r.size() != 0 || exp_wq.size() != 0 ||
           stor_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        chk("drain_timeout", 1'b1, 1'b0);
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_desc_ready"}, desc_ready, 1'b1);
    chk({tag, "_way_req_valid"}, way_req_valid, 1'b0);
    chk({tag, "_way_rsp_ready"}, way_rsp_ready, 1'b0);
    chk({tag, "_r_valid"}, r_valid, 1'b0);
    chk({tag, "_unlock_req"}, unlock_req, 1'b0);
  endtask

  task automatic set_at_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int bw, br, bu, bl, bb, bc;
    rst = 1'b1; r_ready = 1'b1; unlock_gnt = 1'b1; way_req_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("in_reset");
    set_at_edge();
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_reset");

    // INCR len=3 size=3 at 0x40: blk offsets 0..3, one rlast, one unlock.
    bw = n_wreq; bl = n_rlast; bu = n_unl; bb = blk_log.size(); bc = desc_cyc.size();
    desc_q.push_back(mk_desc(6'd5, 64'h40, 8'd3, 3'd3, 2'b01, 2'b00, 1'b1, 8'h04));
    drain(200);
    chk("t1_nreq", 32'(n_wreq - bw), 32'd4);
    for (int k = 0; k < 4; k++) chk("t1_blk", blk_log[bb + k], 3'(k));
    chk("t1_first_req_latency", 32'(wreq_cyc[bb] - desc_cyc[bc]), 32'd1);
    chk("t1_rlast", 32'(n_rlast - bl), 32'd1);
    chk("t1_unlocks", 32'(n_unl - bu), 32'd1);
    chk("t1_unlock_val", last_unl, 16'h0104);

    // SLVERR len=1: no storage reads, zero data, unlock on 2nd beat.
    bw = n_wreq; br = n_r; bu = n_unl;
    desc_q.push_back(mk_desc(6'd9, 64'h1000, 8'd1, 3'd3, 2'b01, 2'b10, 1'b1, 8'h10));
    drain(200);
    chk("t2_nreq", 32'(n_wreq - bw), 32'd0);
    chk("t2_nr", 32'(n_r - br), 32'd2);
    chk("t2_unlocks", 32'(n_unl - bu), 32'd1);
    chk("t2_data", last_r[66:3], 64'h0);
    chk("t2_resp", last_r[2:1], 2'b10);
    chk("t2_unlock_val", last_unl, 16'h4010);

    // FIXED len=2: three reads, same blk offset.
    bw = n_wreq; bb = blk_log.size();
    desc_q.push_back(mk_desc(6'd1, 64'h88, 8'd2, 3'd3, 2'b00, 2'b00, 1'b1, 8'h01));
    drain(200);
    chk("t3_nreq", 32'(n_wreq - bw), 32'd3);
    for (int k = 0; k < 3; k++) chk("t3_blk", blk_log[bb + k], 3'd1);

    // R backpressure: issue stops at the metadata FIFO depth, nothing lost.
    set_at_edge();
    r_ready = 1'b0;
    bw = n_wreq; br = n_r;
    desc_q.push_back(mk_desc(6'd2, 64'h200, 8'd7, 3'd3, 2'b01, 2'b00, 1'b1, 8'h02));
    repeat (10) @(negedge clk);
    chk("t4_stalled_nreq", 32'(n_wreq - bw), 32'd2);
    chk("t4_stalled_nr", 32'(n_r - br), 32'd0);
    set_at_edge();
    r_ready = 1'b1;
    drain(300);
    chk("t4_nreq", 32'(n_wreq - bw), 32'd8);
    chk("t4_nr", 32'(n_r - br), 32'd8);

    // Unlock grant withheld on the final beat; last=0 descriptor.
    set_at_edge();
    unlock_gnt = 1'b0;
    br = n_r; bu = n_unl; bl = n_rlast;
    desc_q.push_back(mk_desc(6'd3, 64'h300, 8'd1, 3'd3, 2'b01, 2'b00, 1'b0, 8'h20));
    repeat (10) @(negedge clk);
    chk("t5_held_nr", 32'(n_r - br), 32'd1);
    chk("t5_held_unl", 32'(n_unl - bu), 32'd0);
    set_at_edge();
    unlock_gnt = 1'b1;
    drain(200);
    chk("t5_nr", 32'(n_r - br), 32'd2);
    chk("t5_unl", 32'(n_unl - bu), 32'd1);
    chk("t5_rlast", 32'(n_rlast - bl), 32'd0);

    // Back-to-back descriptors with zero bubble.
    bc = desc_cyc.size();
    desc_q.push_back(mk_desc(6'd4, 64'h500, 8'd0, 3'd3, 2'b01, 2'b00, 1'b1, 8'h08));
    desc_q.push_back(mk_desc(6'd6, 64'h548, 8'd0, 3'd3, 2'b01, 2'b00, 1'b1, 8'h40));
    desc_q.push_back(mk_desc(6'd7, 64'h600, 8'd1, 3'd2, 2'b01, 2'b00, 1'b1, 8'h80));
    drain(300);
    chk("t6_b2b_gap", 32'(desc_cyc[bc + 1] - desc_cyc[bc]), 32'd1);

    // Reset mid-burst, then a clean descriptor.
    desc_q.push_back(mk_desc(6'd8, 64'h400, 8'd7, 3'd3, 2'b01, 2'b00, 1'b1, 8'h01));
    repeat (4) @(negedge clk);
    set_at_edge();
    rst = 1'b1;
    set_at_edge();
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    bw = n_wreq; bu = n_unl;
    desc_q.push_back(mk_desc(6'd10, 64'h40, 8'd1, 3'd3, 2'b01, 2'b00, 1'b1, 8'h80));
    drain(200);
    chk("t7_nreq", 32'(n_wreq - bw), 32'd2);
    chk("t7_unl", 32'(n_unl - bu), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
